// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use and HI/LO stall control, HI/LO busy tracker.
// Latency: forward selects and stall controls are combinational; BUSY/DONE/STALL_CYCLES are registered.
// Backpressure: any hazard drops PC_LE/IFID_LE and injects an ID/EX bubble until the hazard clears.
module hazard_forward_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RS,
  input  logic        ID_USES_RT,
  input  logic        ID_MULDIV_START,
  input  logic        ID_MULDIV_IS_DIV,
  input  logic        ID_READS_HILO,
  input  logic [4:0]  EX_RD,
  input  logic [4:0]  MEM_RD,
  input  logic [4:0]  WB_RD,
  input  logic        EX_RF_ENABLE,
  input  logic        MEM_RF_ENABLE,
  input  logic        WB_RF_ENABLE,
  input  logic        EX_LOAD_INSTR,
  output logic        PC_LE,
  output logic        IFID_LE,
  output logic        IDEX_NOP,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic        MULDIV_BUSY,
  output logic        MULDIV_DONE,
  output logic [15:0] STALL_CYCLES
);

  // Forward select encoding shared by both operand muxes.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Busy lengths truncated to the 6-bit counter; legal range is 1..63.
  localparam logic [5:0] MULT_LEN = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LEN  = 6'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_stall_cnt;

  // A source is "live" only when the instruction reads it and it is not r0.
  logic        w_rs_live;
  logic        w_rt_live;
  logic        w_ex_wr;
  logic        w_mem_wr;
  logic        w_wb_wr;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_lu_rs;
  logic        w_lu_rt;
  logic        w_load_use;
  logic        w_hilo_haz;
  logic        w_stall;
  logic        w_accept;
  logic [5:0]  w_load_len;

  assign w_rs_live = ID_USES_RS && (ID_RS != 5'd0);
  assign w_rt_live = ID_USES_RT && (ID_RT != 5'd0);

  // A writer that targets r0 can never satisfy a live source, so no extra RD!=0 term is needed here.
  assign w_ex_wr  = EX_RF_ENABLE;
  assign w_mem_wr = MEM_RF_ENABLE;
  assign w_wb_wr  = WB_RF_ENABLE;

  // Operand A source: youngest matching writer wins (EX, then MEM, then WB).
  always_comb begin
    w_fwd_a = FWD_RF;
    if (w_rs_live) begin
      if (w_ex_wr && (EX_RD == ID_RS)) begin
        w_fwd_a = FWD_EX;
      end else if (w_mem_wr && (MEM_RD == ID_RS)) begin
        w_fwd_a = FWD_MEM;
      end else if (w_wb_wr && (WB_RD == ID_RS)) begin
        w_fwd_a = FWD_WB;
      end
    end
  end

  // Operand B source: same priority ladder against RT.
  always_comb begin
    w_fwd_b = FWD_RF;
    if (w_rt_live) begin
      if (w_ex_wr && (EX_RD == ID_RT)) begin
        w_fwd_b = FWD_EX;
      end else if (w_mem_wr && (MEM_RD == ID_RT)) begin
        w_fwd_b = FWD_MEM;
      end else if (w_wb_wr && (WB_RD == ID_RT)) begin
        w_fwd_b = FWD_WB;
      end
    end
  end

  // Load data is not available until MEM, so a load in EX feeding a live source must bubble.
  always_comb begin
    w_lu_rs    = w_rs_live && (EX_RD == ID_RS);
    w_lu_rt    = w_rt_live && (EX_RD == ID_RT);
    w_load_use = EX_LOAD_INSTR && EX_RF_ENABLE && (EX_RD != 5'd0) && (w_lu_rs || w_lu_rt);
  end

  // HI/LO is unusable while a multiply/divide is in flight, including its DONE cycle.
  assign w_hilo_haz = r_busy && (ID_READS_HILO || ID_MULDIV_START);
  assign w_stall    = w_load_use || w_hilo_haz;

  // A start is taken only from IDLE and only when ID is actually advancing this cycle.
  assign w_accept   = (r_state == S_IDLE) && ID_MULDIV_START && !w_stall;
  assign w_load_len = ID_MULDIV_IS_DIV ? DIV_LEN : MULT_LEN;

  // HI/LO tracker: load the length on accept, count down, return to IDLE after the CNT==1 cycle.
  // BUSY/DONE are registered alongside the state so they never glitch with ID inputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= w_load_len;
            r_busy  <= 1'b1;
            r_done  <= (w_load_len == 6'd1);
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            // Next cycle is the last one exactly when the count now reads 2.
            r_done <= (r_cnt == 6'd2);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 6'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Stall-cycle statistic; sticks at all-ones instead of wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign PC_LE        = !w_stall;
  assign IFID_LE      = !w_stall;
  assign IDEX_NOP     = w_stall;
  assign FWD_A        = w_fwd_a;
  assign FWD_B        = w_fwd_b;
  assign MULDIV_BUSY  = r_busy;
  assign MULDIV_DONE  = r_done;
  assign STALL_CYCLES = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus randomized traffic vs a timestamp model.
// Latency: checks combinational outputs mid-cycle, registered outputs after each posedge.
// Backpressure: model predicts stall/bubble from the hazard rules and the busy window.
module tb_hazard_forward_unit;

  localparam int MC = 4;
  localparam int DC = 32;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ID_RS, ID_RT;
  logic        ID_USES_RS, ID_USES_RT;
  logic        ID_MULDIV_START, ID_MULDIV_IS_DIV, ID_READS_HILO;
  logic [4:0]  EX_RD, MEM_RD, WB_RD;
  logic        EX_RF_ENABLE, MEM_RF_ENABLE, WB_RF_ENABLE;
  logic        EX_LOAD_INSTR;
  logic        PC_LE, IFID_LE, IDEX_NOP;
  logic [1:0]  FWD_A, FWD_B;
  logic        MULDIV_BUSY, MULDIV_DONE;
  logic [15:0] STALL_CYCLES;

  hazard_forward_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT),
    .ID_MULDIV_START(ID_MULDIV_START), .ID_MULDIV_IS_DIV(ID_MULDIV_IS_DIV),
    .ID_READS_HILO(ID_READS_HILO),
    .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
    .EX_RF_ENABLE(EX_RF_ENABLE), .MEM_RF_ENABLE(MEM_RF_ENABLE), .WB_RF_ENABLE(WB_RF_ENABLE),
    .EX_LOAD_INSTR(EX_LOAD_INSTR),
    .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IDEX_NOP(IDEX_NOP),
    .FWD_A(FWD_A), .FWD_B(FWD_B),
    .MULDIV_BUSY(MULDIV_BUSY), .MULDIV_DONE(MULDIV_DONE),
    .STALL_CYCLES(STALL_CYCLES)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: cycle index plus the [start,end] window of the current HI/LO operation.
  int cyc = 0;
  int m_bs = 0;
  int m_be = -1;
  int m_stalls = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic uses);
    if (!uses || src == 5'd0) return 2'd0;
    if (EX_RF_ENABLE && EX_RD == src) return 2'd1;
    if (MEM_RF_ENABLE && MEM_RD == src) return 2'd2;
    if (WB_RF_ENABLE && WB_RD == src) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit ref_busy();
    return (cyc >= m_bs) && (cyc <= m_be);
  endfunction

  function automatic bit ref_lu();
    bit hit_rs, hit_rt;
    hit_rs = ID_USES_RS && ID_RS != 5'd0 && ID_RS == EX_RD;
    hit_rt = ID_USES_RT && ID_RT != 5'd0 && ID_RT == EX_RD;
    return EX_LOAD_INSTR && EX_RF_ENABLE && EX_RD != 5'd0 && (hit_rs || hit_rt);
  endfunction

  function automatic bit ref_stall();
    return ref_lu() || (ref_busy() && (ID_READS_HILO || ID_MULDIV_START));
  endfunction

  task automatic check_all();
    bit st;
    st = ref_stall();
    chk("pc_le",    32'(PC_LE),        32'(!st));
    chk("ifid_le",  32'(IFID_LE),      32'(!st));
    chk("idex_nop", 32'(IDEX_NOP),     32'(st));
    chk("fwd_a",    32'(FWD_A),        32'(ref_fwd(ID_RS, ID_USES_RS)));
    chk("fwd_b",    32'(FWD_B),        32'(ref_fwd(ID_RT, ID_USES_RT)));
    chk("busy",     32'(MULDIV_BUSY),  32'(ref_busy()));
    chk("done",     32'(MULDIV_DONE),  32'(ref_busy() && cyc == m_be));
    chk("stallcnt", 32'(STALL_CYCLES), 32'(m_stalls));
  endtask

  // Advance the model across one posedge using the inputs currently applied.
  task automatic model_update();
    bit st;
    if (Reset) begin
      m_bs = 0; m_be = -1; m_stalls = 0;
    end else begin
      st = ref_stall();
      if (st && m_stalls < 65535) m_stalls++;
      if (!ref_busy() && ID_MULDIV_START && !st) begin
        m_bs = cyc + 1;
        m_be = cyc + (ID_MULDIV_IS_DIV ? DC : MC);
      end
    end
    cyc++;
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic tick(input bit do_check);
    #1;
    if (do_check) check_all();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
  endtask

  task automatic clear_inputs();
    ID_RS = 0; ID_RT = 0; ID_USES_RS = 0; ID_USES_RT = 0;
    ID_MULDIV_START = 0; ID_MULDIV_IS_DIV = 0; ID_READS_HILO = 0;
    EX_RD = 0; MEM_RD = 0; WB_RD = 0;
    EX_RF_ENABLE = 0; MEM_RF_ENABLE = 0; WB_RF_ENABLE = 0;
    EX_LOAD_INSTR = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    tick(0);
    Reset = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    Reset = 1;
    @(negedge Clk);
    tick(0);
    tick(0);
    Reset = 0;

    // Reset state with all inputs low.
    #1;
    chk("rst_pc_le",    32'(PC_LE), 32'd1);
    chk("rst_ifid_le",  32'(IFID_LE), 32'd1);
    chk("rst_idex_nop", 32'(IDEX_NOP), 32'd0);
    chk("rst_fwd_a",    32'(FWD_A), 32'd0);
    chk("rst_fwd_b",    32'(FWD_B), 32'd0);
    chk("rst_busy",     32'(MULDIV_BUSY), 32'd0);
    chk("rst_stallcnt", 32'(STALL_CYCLES), 32'd0);
    tick(1);

    // Forward priority EX > MEM > WB.
    ID_RS = 5; ID_USES_RS = 1; EX_RD = 5; MEM_RD = 5; WB_RD = 5;
    EX_RF_ENABLE = 1; MEM_RF_ENABLE = 1; WB_RF_ENABLE = 1;
    #1 chk("prio_ex", 32'(FWD_A), 32'd1);
    EX_RF_ENABLE = 0;
    #1 chk("prio_mem", 32'(FWD_A), 32'd2);
    MEM_RF_ENABLE = 0;
    #1 chk("prio_wb", 32'(FWD_A), 32'd3);
    tick(1);

    // Register zero never matches, even against a load.
    clear_inputs();
    ID_USES_RS = 1; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
    #1 chk("r0_fwd_a", 32'(FWD_A), 32'd0);
    chk("r0_nop", 32'(IDEX_NOP), 32'd0);
    tick(1);
    chk("r0_stallcnt", 32'(STALL_CYCLES), 32'd0);

    // Load-use on RT: one bubble.
    clear_inputs();
    EX_LOAD_INSTR = 1; EX_RF_ENABLE = 1; EX_RD = 8; ID_RT = 8; ID_USES_RT = 1;
    #1 chk("lu_pc_le", 32'(PC_LE), 32'd0);
    chk("lu_ifid_le", 32'(IFID_LE), 32'd0);
    chk("lu_nop", 32'(IDEX_NOP), 32'd1);
    tick(1);
    clear_inputs();
    #1 chk("lu_nop_after", 32'(IDEX_NOP), 32'd0);
    chk("lu_stallcnt", 32'(STALL_CYCLES), 32'd1);
    tick(1);

    // Multiply with MFLO waiting behind it.
    do_reset();
    ID_MULDIV_START = 1;
    tick(1);
    clear_inputs();
    ID_READS_HILO = 1;
    for (int i = 1; i <= MC; i++) begin
      #1 chk("mul_busy", 32'(MULDIV_BUSY), 32'd1);
      chk("mul_nop", 32'(IDEX_NOP), 32'd1);
      chk("mul_done", 32'(MULDIV_DONE), 32'(i == MC));
      tick(1);
    end
    #1 chk("mul_busy_end", 32'(MULDIV_BUSY), 32'd0);
    chk("mul_nop_end", 32'(IDEX_NOP), 32'd0);
    chk("mul_stallcnt", 32'(STALL_CYCLES), 32'd4);
    tick(1);

    // Divide aborted by reset in busy cycle 10.
    do_reset();
    ID_MULDIV_START = 1; ID_MULDIV_IS_DIV = 1;
    tick(1);
    clear_inputs();
    for (int i = 1; i <= 9; i++) tick(1);
    Reset = 1;
    #1 chk("div_busy_pre", 32'(MULDIV_BUSY), 32'd1);
    tick(1);
    Reset = 0;
    #1 chk("div_busy_rst", 32'(MULDIV_BUSY), 32'd0);
    chk("div_done_rst", 32'(MULDIV_DONE), 32'd0);
    chk("div_stallcnt", 32'(STALL_CYCLES), 32'd0);
    for (int i = 0; i < 30; i++) tick(1);

    // Randomized traffic over a small register window so matches are frequent.
    for (int i = 0; i < 3000; i++) begin
      Reset            = ($urandom_range(0, 99) == 0);
      ID_RS            = 5'($urandom_range(0, 3));
      ID_RT            = 5'($urandom_range(0, 3));
      ID_USES_RS       = 1'($urandom);
      ID_USES_RT       = 1'($urandom);
      ID_MULDIV_START  = ($urandom_range(0, 3) == 0);
      ID_MULDIV_IS_DIV = ($urandom_range(0, 7) == 0);
      ID_READS_HILO    = ($urandom_range(0, 3) == 0);
      EX_RD            = 5'($urandom_range(0, 3));
      MEM_RD           = 5'($urandom_range(0, 3));
      WB_RD            = 5'($urandom_range(0, 3));
      EX_RF_ENABLE     = 1'($urandom);
      MEM_RF_ENABLE    = 1'($urandom);
      WB_RF_ENABLE     = 1'($urandom);
      EX_LOAD_INSTR    = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    Reset = 0;

    // Saturation: keep MFHI and re-issued divides pending until the counter tops out.
    do_reset();
    ID_READS_HILO = 1; ID_MULDIV_START = 1; ID_MULDIV_IS_DIV = 1;
    for (int i = 0; i < 80000 && m_stalls < 65535; i++) tick(0);
    for (int i = 0; i < 40; i++) tick(0);
    #1 chk("sat_stallcnt", 32'(STALL_CYCLES), 32'hFFFF);
    check_all();
    tick(1);
    chk("sat_hold", 32'(STALL_CYCLES), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
